led_frame_scheduler: RTL

//   Sequences refresh of the 16x16 WS2812 panel. A free-running frame timer triggers each frame.
//   On each trigger the block snapshots the physics 256-bit occupancy matrix into a shadow buffer.
//   It then streams one 24-bit GRB word per physical LED to the ws2812 serializer (valid/ready),
//   and finally enforces the WS2812 latch gap. Sits between physics (matrix producer) and ws2812 (bit driver).

---
 rtl/led_pkg.sv | 14 +
 rtl/pixel_index_map.sv | 15 +
 rtl/led_frame_scheduler.sv | 116 +++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and panel geometry for the LED frame scheduler.
package led_pkg;
  localparam int MATRIX_W = 16;
  localparam int NUM_PIX  = MATRIX_W * MATRIX_W;

  typedef logic [23:0] grb_t;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    STREAM,
    GAP
  } sched_state_t;
endpackage

// File: rtl/pixel_index_map.sv
// Physical LED number to matrix bit index, zero latency; SERPENTINE_EN selects zig-zag wiring.
// Purely combinational, no flow control.
module pixel_index_map
  import led_pkg::*;
(
  input  logic [7:0] k,
  output logic [7:0] idx
);
`ifdef SERPENTINE_EN
  // Odd rows run right-to-left on the panel.
  assign idx = k[4] ? {k[7:4], 4'(MATRIX_W - 1) - k[3:0]} : k;
`else
  assign idx = k;
`endif
endmodule

// File: rtl/led_frame_scheduler.sv
// Frame sequencer: snapshot matrix, stream 24-bit GRB per LED, hold latch gap (SERPENTINE_EN in pixel_index_map).
// Tick -> frame_start +1 -> first pixel +2; pixels advance only on pix_valid&&pix_ready.
module led_frame_scheduler #(
  parameter int          FRAME_CYCLES = 416667,
  parameter int          RESET_CYCLES = 1500,
  parameter int          NUM_PIX      = led_pkg::NUM_PIX,
  parameter logic [23:0] ON_COLOR     = 24'h001000,
  parameter logic [23:0] OFF_COLOR    = 24'h000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] matrix_in,
  input  logic         pix_ready,
  output logic         pix_valid,
  output logic [23:0]  pix_data,
  output logic         pix_last,
  output logic         frame_start,
  output logic         busy,
  output logic [15:0]  frame_count,
  output logic [7:0]   overrun_cnt
);
  import led_pkg::*;

  localparam int TW = $clog2(FRAME_CYCLES);
  localparam int GW = $clog2(RESET_CYCLES + 1);

  sched_state_t                     state;
  logic [TW-1:0]                    timer;
  logic [GW-1:0]                    gap_cnt;
  logic [MATRIX_W*MATRIX_W-1:0]     shadow;
  logic [7:0]                       pix_idx;
  logic                             tick;
  logic                             hs;
  logic [7:0]                       map_k;
  logic [7:0]                       map_idx;
  logic                             map_bit;
  grb_t                             next_color;

  assign tick = (timer == TW'(FRAME_CYCLES - 1));
  assign hs   = pix_valid & pix_ready;

  // In LATCH the shadow is not loaded yet, so pixel 0 is read straight from matrix_in.
  assign map_k      = (state == LATCH) ? 8'd0 : pix_idx + 8'd1;
  assign map_bit    = (state == LATCH) ? matrix_in[map_idx] : shadow[map_idx];
  assign next_color = map_bit ? ON_COLOR : OFF_COLOR;

  pixel_index_map u_map (
    .k   (map_k),
    .idx (map_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      gap_cnt     <= '0;
      shadow      <= '0;
      pix_idx     <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_last    <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      overrun_cnt <= '0;
    end else begin
      frame_start <= 1'b0;
      timer       <= tick ? '0 : timer + 1'b1;
      if (tick && state != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (tick) begin
            state       <= LATCH;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        LATCH: begin
          shadow    <= matrix_in;
          pix_idx   <= '0;
          pix_valid <= 1'b1;
          pix_data  <= next_color;
          pix_last  <= (NUM_PIX == 1);
          state     <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            if (pix_last) begin
              pix_valid   <= 1'b0;
              pix_last    <= 1'b0;
              pix_data    <= '0;
              gap_cnt     <= '0;
              frame_count <= frame_count + 16'd1;
              state       <= GAP;
            end else begin
              pix_idx  <= pix_idx + 8'd1;
              pix_data <= next_color;
              pix_last <= ((pix_idx + 8'd1) == 8'(NUM_PIX - 1));
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(RESET_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
